obu_writer: RTL and testbench

OBU_WRITER -- requirements
Module: obu_writer

---
 rtl/obu_writer_if.sv | 33 +++
 rtl/obu_writer.sv | 170 +++++++++++++++++
 tb/tb_obu_writer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/obu_writer_if.sv
// Handshake and bus bundle for obu_writer.
//   start/obu_type/obu_size : OBU request (type and payload length)
//   busy/err                : writer status, err pulses on a rejected request
//   in_byte/in_valid/in_ready : payload byte stream into the writer
//   out_data/out_push/out_full/out_last/out_end_len : packed words to the FIFO
// master drives requests, payload and out_full; slave is the writer.
interface obu_writer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [3:0]            obu_type;
    logic [31:0]           obu_size;
    logic                  busy;
    logic                  err;
    logic [7:0]            in_byte;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_push;
    logic                  out_full;
    logic                  out_last;
    logic [4:0]            out_end_len;

    modport master (
        output start, obu_type, obu_size, in_byte, in_valid, out_full,
        input  busy, err, in_ready, out_data, out_push, out_last, out_end_len
    );

    modport slave (
        input  start, obu_type, obu_size, in_byte, in_valid, out_full,
        output busy, err, in_ready, out_data, out_push, out_last, out_end_len
    );
endinterface

// File: rtl/obu_writer.sv
// OBU writer: emits header byte, leb128 size field and payload as one byte
// stream, packed MSB-first into 32-bit words for a downstream FIFO.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   io_bus : obu_writer_if.slave (request, status, payload in, word out)
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start; bad sizes pulse err
// S_HDR     | append header byte
// S_SIZE    | append leb128 size bytes, least significant group first
// S_PAYLOAD | accept payload bytes through in_valid/in_ready
// S_FLUSH   | turn a partial accumulator into the final word, wait its push
module obu_writer #(
    parameter int DATA_WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    obu_writer_if.slave io_bus
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SIZE, S_PAYLOAD, S_FLUSH} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_type;
    logic [27:0]           r_size;
    logic [27:0]           r_leb;
    logic [27:0]           r_rem;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [1:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_held;
    logic                  r_held_vld;
    logic                  r_held_last;
    logic [4:0]            r_held_len;
    logic                  r_err;

    logic       w_push;
    logic       w_slot_free;
    logic       w_bad_size;
    logic       w_leb_more;
    logic       w_start_ok;
    logic       w_app;
    logic [7:0] w_app_byte;
    logic       w_app_final;
    logic       w_flush_load;
    logic       w_in_ready;

    assign w_push      = r_held_vld & ~io_bus.out_full;
    // A byte may complete a new word in the same cycle the held word leaves.
    assign w_slot_free = ~r_held_vld | ~io_bus.out_full;
    assign w_bad_size  = |io_bus.obu_size[31:28];
    assign w_leb_more  = |r_leb[27:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_start_ok   = 1'b0;
        w_app        = 1'b0;
        w_app_byte   = 8'h00;
        w_app_final  = 1'b0;
        w_flush_load = 1'b0;
        w_in_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start && !w_bad_size) begin
                    w_start_ok = 1'b1;
                    w_next     = S_HDR;
                end
            end
            S_HDR: begin
                if (w_slot_free) begin
                    w_app      = 1'b1;
                    w_app_byte = {1'b0, r_type, 3'b010};
                    w_next     = S_SIZE;
                end
            end
            S_SIZE: begin
                if (w_slot_free) begin
                    w_app      = 1'b1;
                    w_app_byte = {w_leb_more, r_leb[6:0]};
                    if (!w_leb_more) w_next = (r_size == 28'd0) ? S_FLUSH : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                w_in_ready = w_slot_free;
                if (io_bus.in_valid && w_slot_free) begin
                    w_app      = 1'b1;
                    w_app_byte = io_bus.in_byte;
                    if (r_rem == 28'd1) begin
                        w_app_final = 1'b1;
                        w_next      = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // A held last word implies an empty accumulator, so load and
                // final push never coincide.
                if (r_cnt != 2'd0 && w_slot_free) w_flush_load = 1'b1;
                if (w_push && r_held_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_type      <= '0;
            r_size      <= '0;
            r_leb       <= '0;
            r_rem       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_held      <= '0;
            r_held_vld  <= 1'b0;
            r_held_last <= 1'b0;
            r_held_len  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && io_bus.start && w_bad_size;
            if (w_start_ok) begin
                r_type <= io_bus.obu_type;
                r_size <= io_bus.obu_size[27:0];
                r_leb  <= io_bus.obu_size[27:0];
                r_rem  <= io_bus.obu_size[27:0];
            end
            if (r_state == S_SIZE && w_app)    r_leb <= r_leb >> 7;
            if (r_state == S_PAYLOAD && w_app) r_rem <= r_rem - 28'd1;

            if (w_push) r_held_vld <= 1'b0;

            if (w_app) begin
                r_cnt <= r_cnt + 2'd1;
                case (r_cnt)
                    2'd0: r_acc[31:24] <= w_app_byte;
                    2'd1: r_acc[23:16] <= w_app_byte;
                    2'd2: r_acc[15:8]  <= w_app_byte;
                    default: begin
                        r_held      <= {r_acc[31:8], w_app_byte};
                        r_held_vld  <= 1'b1;
                        r_held_last <= w_app_final;
                        r_held_len  <= 5'd0;
                        r_acc       <= '0;
                    end
                endcase
            end

            if (w_flush_load) begin
                r_held      <= r_acc;
                r_held_vld  <= 1'b1;
                r_held_last <= 1'b1;
                r_held_len  <= {r_cnt, 3'b000};
                r_acc       <= '0;
                r_cnt       <= 2'd0;
            end
        end
    end

    assign io_bus.busy        = (r_state != S_IDLE);
    assign io_bus.err         = r_err;
    assign io_bus.in_ready    = w_in_ready;
    assign io_bus.out_data    = r_held;
    assign io_bus.out_push    = w_push;
    assign io_bus.out_last    = w_push & r_held_last;
    assign io_bus.out_end_len = w_push ? r_held_len : 5'd0;
endmodule

// File: tb/tb_obu_writer.sv
module tb_obu_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obu_writer_if bus ();
    obu_writer dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

    int total = 0;
    int bad   = 0;

    logic [7:0]  pay[$];
    logic [31:0] ew[$];
    logic [4:0]  elen[$];
    bit          elast[$];
    logic [3:0]  cur_type;
    logic [31:0] cur_size;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: whole byte stream as a list, then cut into 4-byte words.
    task automatic build(input logic [3:0] typ, input logic [31:0] sz);
        logic [7:0]  s[$];
        logic [31:0] w;
        int          v, b, n;
        cur_type = typ;
        cur_size = sz;
        ew.delete(); elen.delete(); elast.delete();
        s.push_back(8'({1'b0, typ, 1'b0, 1'b1, 1'b0}));
        v = int'(sz);
        do begin
            b = v % 128;
            v = v / 128;
            if (v != 0) b += 128;
            s.push_back(8'(b));
        end while (v != 0);
        foreach (pay[i]) s.push_back(pay[i]);
        for (int i = 0; i < s.size(); i += 4) begin
            n = (s.size() - i >= 4) ? 4 : s.size() - i;
            w = 32'd0;
            for (int j = 0; j < n; j++) w |= 32'(s[i+j]) << (24 - 8*j);
            ew.push_back(w);
            elast.push_back(i + 4 >= s.size());
            elen.push_back((i + 4 >= s.size() && n != 4) ? 5'(8*n) : 5'd0);
        end
    endtask

    task automatic fill_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    // mode 0: in_valid=1, out_full=0; 1: random; 2: out_full high cycles 5..9
    task automatic run_obu(input int mode, input int exp_last_cyc);
        int          cyc, pidx, last_cyc, budget;
        bit          done;
        logic [31:0] first_w;
        first_w  = ew[0];
        budget   = 4 * int'(cur_size) + 60;
        done     = 0;
        pidx     = 0;
        last_cyc = -1;
        bus.start    = 1'b1;
        bus.obu_type = cur_type;
        bus.obu_size = cur_size;
        bus.in_valid = 1'b0;
        bus.out_full = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (!done && cyc < budget) begin
            bus.in_byte  = (pidx < pay.size()) ? pay[pidx] : 8'($urandom);
            bus.in_valid = (mode == 1) ? ($urandom % 4 != 0) : 1'b1;
            bus.out_full = (mode == 1) ? ($urandom % 3 == 0) :
                           (mode == 2) ? (cyc >= 5 && cyc <= 9) : 1'b0;
            if (mode == 1) begin
                bus.start    = ($urandom % 8 == 0);
                bus.obu_size = $urandom_range(0, 50);
            end
            #3;
            check("err_quiet", bus.err, 0);
            check("push_while_full", bus.out_push & bus.out_full, 0);
            check("in_ready_range", bus.in_ready && (pidx >= int'(cur_size)), 0);
            if (!bus.out_push) check("last_len_idle", {bus.out_last, bus.out_end_len}, 0);
            if (mode == 2 && cyc >= 5 && cyc <= 9) begin
                check("stall_push", bus.out_push, 0);
                check("stall_in_ready", bus.in_ready, 0);
                check("stall_data", bus.out_data, first_w);
            end
            if (bus.out_push) begin
                if (ew.size() == 0) check("extra_push", 1, 0);
                else begin
                    check("word_data", bus.out_data, ew[0]);
                    check("word_last", bus.out_last, elast[0]);
                    check("word_end_len", bus.out_end_len, elen[0]);
                    void'(ew.pop_front()); void'(elen.pop_front()); void'(elast.pop_front());
                    if (ew.size() == 0) begin
                        done     = 1;
                        last_cyc = cyc;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) pidx++;
            @(posedge clk); #1;
            if (!done) cyc++;
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_full = 1'b0;
        if (!done) check("timeout", 0, 1);
        else begin
            #3;
            check("busy_after_last", bus.busy, 0);
            check("bytes_consumed", pidx, cur_size);
            if (exp_last_cyc >= 0) check("last_push_cycle", last_cyc, exp_last_cyc);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_push"}, bus.out_push, 0);
        check({tag, "_last"}, bus.out_last, 0);
        check({tag, "_end_len"}, bus.out_end_len, 0);
        check({tag, "_data"}, bus.out_data, 0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.obu_type = 4'd0;
        bus.obu_size = 32'd0;
        bus.in_byte  = 8'd0;
        bus.in_valid = 1'b0;
        bus.out_full = 1'b0;
        #2;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // type 1, three payload bytes
        pay = '{8'hAA, 8'hBB, 8'hCC};
        build(4'd1, 32'd3);
        run_obu(0, 7);

        // empty payload
        pay.delete();
        build(4'd2, 32'd0);
        run_obu(0, 4);

        // two-byte leb size field, 51 words
        fill_pay(200);
        build(4'd6, 32'd200);
        run_obu(0, -1);

        // FIFO full for 5 cycles when the only word completes
        fill_pay(2);
        build(4'd1, 32'd2);
        run_obu(2, 10);

        // oversize request
        bus.start    = 1'b1;
        bus.obu_type = 4'd3;
        bus.obu_size = 32'h1000_0000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        #2;
        check("err_pulse", bus.err, 1);
        check("err_busy", bus.busy, 0);
        @(posedge clk); #3;
        check("err_clear", bus.err, 0);
        check("err_busy2", bus.busy, 0);
        @(posedge clk); #1;

        // randomized OBUs with stalls, gaps and ignored starts while busy
        for (int k = 0; k < 8; k++) begin
            fill_pay($urandom_range(0, 37));
            build(4'($urandom), 32'(pay.size()));
            run_obu(1, -1);
        end

        // reset in the middle of the payload
        fill_pay(10);
        build(4'd5, 32'd10);
        bus.start    = 1'b1;
        bus.obu_type = 4'd5;
        bus.obu_size = 32'd10;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h77;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill_pay(1);
        build(4'd1, 32'd1);
        run_obu(0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
